// File: rtl/hddemo_pkg.sv
// Shared types and MISR arithmetic for the HD demo signature readout.
package hddemo_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, DONE} state_t;

  localparam logic [15:0] DEFAULT_POLY = 16'h1021;
  localparam logic [15:0] DEFAULT_SEED = 16'h0000;

  // Width-generic MISR step on a 32-bit carrier; w is the signature width (<= 32).
  function automatic logic [31:0] misr_next(input logic [31:0] misr,
                                            input logic [31:0] data,
                                            input logic [31:0] poly,
                                            input int          w);
    logic [31:0] mask;
    logic [31:0] msb;
    mask = (w >= 32) ? '1 : ((32'h1 << w) - 32'h1);
    msb  = 32'h1 << (w - 1);
    return (((misr << 1) ^ (((misr & msb) != 32'h0) ? poly : 32'h0)) ^ data) & mask;
  endfunction

endpackage

// File: rtl/hd_misr_core.sv
// MISR register: seed load and per-sample step, with the next value exposed.
module hd_misr_core
  import hddemo_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                SIG_W  = 16,
  parameter logic [SIG_W-1:0]  POLY   = SIG_W'(DEFAULT_POLY),
  parameter logic [SIG_W-1:0]  SEED   = SIG_W'(DEFAULT_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] data,
  output logic [SIG_W-1:0]  misr,
  output logic [SIG_W-1:0]  misr_nxt
);

  logic [31:0] nxt_full;

  assign nxt_full = misr_next(32'(misr), 32'(data), 32'(POLY), SIG_W);
  assign misr_nxt = nxt_full[SIG_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    misr <= SEED;
    else if (load) misr <= SEED;
    else if (step) misr <= misr_nxt;
  end

endmodule

// File: rtl/hd_misr_readout.sv
// Captures a window of samples into a MISR, then serializes the signature MSB first.
module hd_misr_readout
  import hddemo_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                SIG_W  = 16,
  parameter logic [SIG_W-1:0]  POLY   = SIG_W'(DEFAULT_POLY),
  parameter logic [SIG_W-1:0]  SEED   = SIG_W'(DEFAULT_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [7:0]        win_len,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              sig_bit,
  output logic              sig_strobe,
  output logic [SIG_W-1:0]  signature
);

  localparam int BW = $clog2(SIG_W);

  state_t            state, state_nxt;
  logic [8:0]        count;
  logic [SIG_W-1:0]  shift_reg;
  logic [BW-1:0]     bit_cnt;
  logic [SIG_W-1:0]  misr_nxt;
  logic              misr_load, misr_step;

  hd_misr_core #(.DATA_W(DATA_W), .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (misr_load),
    .step     (misr_step),
    .data     (data_in),
    .misr     (signature),
    .misr_nxt (misr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= IDLE;
    else if (ena) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    misr_load = 1'b0;
    misr_step = 1'b0;
    if (ena) begin
      case (state)
        IDLE, DONE: if (start) begin
          misr_load = 1'b1;
          state_nxt = CAPTURE;
        end
        CAPTURE: begin
          misr_step = 1'b1;
          if (count == 9'd1) state_nxt = SHIFT;
        end
        SHIFT: if (bit_cnt == BW'(SIG_W - 1)) state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Window counter and serializer; the final MISR value is taken from the
  // core's next-state so the shift register loads on the last sample cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (ena) begin
      case (state)
        IDLE, DONE: if (start) count <= {win_len == 8'd0, win_len};
        CAPTURE: begin
          if (count != 9'd0) count <= count - 9'd1;
          if (count == 9'd1) begin
            shift_reg <= misr_nxt;
            bit_cnt   <= '0;
          end
        end
        SHIFT: begin
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt + BW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state == CAPTURE) || (state == SHIFT);
  assign done       = (state == DONE);
  assign sig_strobe = (state == SHIFT);
  assign sig_bit    = sig_strobe & shift_reg[SIG_W-1];

endmodule
